// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// The state encoding is fixed so it can be observed on the debug state port.
package fetch_pkg;

    // Responder control states.
    // The numeric values appear on dbg_state, so keep them stable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        RESP = 2'd3
    } state_t;

    // Bytes per instruction word; byte addresses are divided by this to get word indices.
    localparam int WORD_BYTES = 4;

    // Data value returned alongside an error response.
    localparam logic [31:0] ERR_DATA = 32'h0;

    // Number of low address bits that select a byte within a word.
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

endpackage

// File: rtl/fetch_mem.sv
// Word RAM behind the fetch responder.
// It has one synchronous write port and one registered read port.
// A read and a write to the same word in the same cycle return the old contents (read-before-write).
// Only the read output register is reset; the array contents are not.
module fetch_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_addr_i,
    input  logic [31:0]           wr_data_i,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [31:0]           rd_data_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_data_q;

    // Backdoor write port.
    // It is deliberately independent of reset so the loader can preload during reset.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read.
    // The non-blocking update samples the array before any same-edge write lands.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q <= ERR_DATA;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fetch_responder.sv
// Memory end of the instruction-fetch interface.
// A request is accepted only in IDLE. The responder then waits WAIT_CYCLES cycles and reads
// the word in one READ cycle. The response (word or error) is presented in RESP until it is consumed.
//
// Handshakes: a transfer happens on a posedge where valid and ready are both high.
// req_ready is a decode of the state only and never looks at req_valid.
// The requester holds req_valid/req_addr until req_ready.
// rsp_valid stays high and rsp_data/rsp_err stay stable until rsp_ready is seen.
// rsp_ready is ignored while rsp_valid is low.
module fetch_responder
    import fetch_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [31:0]           req_addr,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    input  logic                  rsp_ready,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    output logic [1:0]            dbg_state
);

    // Memory size in words, as a 32-bit value, for the range comparison.
    localparam logic [31:0] DEPTH_WORDS = 32'(1) << DEPTH_LOG2;

    // Last value the wait counter reaches before the FSM moves on to READ.
    localparam logic [3:0]  WAIT_LAST   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0]           off_bytes;
    logic [31:0]           off_words;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  addr_err;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  rd_en;
    logic [31:0]           mem_rd_data;

    // Error check on the latched address.
    // The full 32-bit offset is range-checked before it is truncated to a word index,
    // so addresses past the top of the memory never alias back onto low words.
    always_comb begin
        off_bytes    = addr_q - BASE_ADDR;
        off_words    = off_bytes >> WORD_SHIFT;
        misaligned   = (addr_q[WORD_SHIFT-1:0] != '0);
        out_of_range = (addr_q < BASE_ADDR) || (off_words >= DEPTH_WORDS);
        addr_err     = misaligned || out_of_range;
        word_idx     = off_words[DEPTH_LOG2-1:0];
    end

    // Next-state logic and the read strobe for the control FSM.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        addr_d      = addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rd_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    wait_cnt_d = 4'd0;
                    state_d    = (WAIT_CYCLES == 0) ? READ : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = READ;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            READ: begin
                // The RAM samples the word on this edge.
                // The error flag is captured alongside it, so data and flag appear together in RESP.
                rd_en       = 1'b1;
                rsp_err_d   = addr_err;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers.
    // Reset aborts any fetch in flight without emitting a response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            addr_q      <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    fetch_mem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (word_idx),
        .rd_data_o (mem_rd_data)
    );

    // Error responses force the data to the error value.
    // The RAM output register holds its last read, so the data stays stable through RESP.
    assign rsp_data  = rsp_err_q ? ERR_DATA : mem_rd_data;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign req_ready = (state_q == IDLE) && !reset;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_responder.sv
// Directed bench for fetch_responder.
// One instance uses two wait states and one uses zero wait states.
// The two instances share the clock, the reset and the backdoor write port.
module tb_fetch_responder;

  localparam int DL = 10;
  localparam int W  = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DL-1:0] wr_addr;
  logic [31:0]   wr_data;

  logic          req_valid, req_ready, rsp_valid, rsp_err, rsp_ready;
  logic [31:0]   req_addr, rsp_data;
  logic [1:0]    dbg_state;

  logic          req_valid0, req_ready0, rsp_valid0, rsp_err0, rsp_ready0;
  logic [31:0]   req_addr0, rsp_data0;
  logic [1:0]    dbg_state0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  logic [31:0] b2b_addr [4] = '{32'hC, 32'h14, 32'hFFC, 32'h6};
  logic [31:0] b2b_data [4] = '{32'hDEADBEEF, 32'h2, 32'hCAFEF00D, 32'h0};
  logic        b2b_err  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  fetch_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W), .BASE_ADDR(32'h0)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_state(dbg_state)
  );

  fetch_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid0), .req_addr(req_addr0), .req_ready(req_ready0),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_err(rsp_err0), .rsp_ready(rsp_ready0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_state(dbg_state0)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bd_write(input logic [DL-1:0] idx, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = idx; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // The request is driven just after edge E and accepted on edge E+1.
  // rsp_valid is expected after edge E+W+2.
  // wr_at=k drives a backdoor write that commits on the k-th edge:
  // k=2 lands while the FSM is in WAIT, and k=W+2 lands on the READ edge.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err,
                          input int wr_at, input logic [DL-1:0] wr_idx, input logic [31:0] wr_dat,
                          input string tag);
    logic [31:0] exp_word;
    exp_q.push_back(exp_data);
    req_valid = 1'b1;
    req_addr  = addr;
    check({tag, "_rdy_idle"}, {31'b0, req_ready}, 32'd1);
    for (int k = 1; k <= W + 2; k++) begin
      if (k == wr_at) begin
        wr_en = 1'b1; wr_addr = wr_idx; wr_data = wr_dat;
      end
      tick();
      wr_en = 1'b0;
      if (k == 1) req_valid = 1'b0;
      if (k < W + 2) begin
        check({tag, "_novalid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
      end
    end
    exp_word = exp_q.pop_front();
    check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, "_data"}, rsp_data, exp_word);
    check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    check({tag, "_state"}, {30'b0, dbg_state}, 32'd3);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_hs_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_hs_rdy"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_hs_state"}, {30'b0, dbg_state}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    req_valid0 = 1'b0; req_addr0 = '0; rsp_ready0 = 1'b0;
    tick();
    // Preload the memory while reset is still asserted.
    bd_write(10'd3, 32'hDEADBEEF);
    bd_write(10'd5, 32'h1);
    bd_write(10'd1023, 32'hCAFEF00D);
    check("rst_rdy", {31'b0, req_ready}, 32'd0);
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_data", rsp_data, 32'h0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_rdy", {31'b0, req_ready}, 32'd1);

    // Basic fetch, then hold the response for 5 cycles while a competing request is ignored.
    do_fetch(32'hC, 32'hDEADBEEF, 1'b0, -1, '0, '0, "f_c");
    req_valid = 1'b1; req_addr = 32'h14;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_data", rsp_data, 32'hDEADBEEF);
      check("hold_rdy", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    handshake("f_c");

    // Misaligned, out-of-range and last-word addresses.
    do_fetch(32'h6, 32'h0, 1'b1, -1, '0, '0, "mis");
    handshake("mis");
    do_fetch(32'h1000, 32'h0, 1'b1, -1, '0, '0, "oor");
    handshake("oor");
    do_fetch(32'hFFC, 32'hCAFEF00D, 1'b0, -1, '0, '0, "last");
    handshake("last");

    // A write on the READ edge is not seen; a write during WAIT is seen.
    do_fetch(32'h14, 32'h1, 1'b0, W + 2, 10'd5, 32'h2, "rbw");
    handshake("rbw");
    bd_write(10'd5, 32'h1);
    do_fetch(32'h14, 32'h2, 1'b0, 2, 10'd5, 32'h2, "wwait");
    handshake("wwait");

    // Reset during WAIT aborts the fetch.
    req_valid = 1'b1; req_addr = 32'hC;
    tick();
    req_valid = 1'b0;
    check("abort_inwait", {30'b0, dbg_state}, 32'd1);
    reset = 1'b1;
    tick();
    check("abort_rdy_rst", {31'b0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("abort_rdy", {31'b0, req_ready}, 32'd1);
    check("abort_state", {30'b0, dbg_state}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_novalid", {31'b0, rsp_valid}, 32'd0);
    end
    do_fetch(32'hC, 32'hDEADBEEF, 1'b0, -1, '0, '0, "after_abort");
    handshake("after_abort");

    // Zero-wait instance: the response appears after edge E+2.
    req_valid0 = 1'b1; req_addr0 = 32'hC;
    tick();
    req_valid0 = 1'b0;
    check("z_lat_nv", {31'b0, rsp_valid0}, 32'd0);
    tick();
    check("z_lat_valid", {31'b0, rsp_valid0}, 32'd1);
    check("z_lat_data", rsp_data0, 32'hDEADBEEF);
    rsp_ready0 = 1'b1;
    tick();
    rsp_ready0 = 1'b0;
    check("z_hs_valid", {31'b0, rsp_valid0}, 32'd0);
    check("z_hs_rdy", {31'b0, req_ready0}, 32'd1);

    // Back-to-back fetches with rsp_ready held high give one response every 3 cycles.
    rsp_ready0 = 1'b1;
    req_valid0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr0 = b2b_addr[i];
      check("b2b_rdy", {31'b0, req_ready0}, 32'd1);
      tick();
      check("b2b_nv_read", {31'b0, rsp_valid0}, 32'd0);
      tick();
      check("b2b_valid", {31'b0, rsp_valid0}, 32'd1);
      check("b2b_data", rsp_data0, b2b_data[i]);
      check("b2b_err", {31'b0, rsp_err0}, {31'b0, b2b_err[i]});
      tick();
      check("b2b_nv_idle", {31'b0, rsp_valid0}, 32'd0);
    end
    req_valid0 = 1'b0;
    rsp_ready0 = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
